lcd_cmd_queue: RTL and testbench

Command queue between the CPU's LCD store port (address 0xff0c) and the SPI output driver. CPU stores push 10-bit LCD words into a FIFO at full bus rate. The queue issues one word at a time to the SPI driver as a single-cycle start pulse. It then waits long enough for the driver to finish the byte before issuing the next word. This lets software write a whole command/data sequence back-to-back without polling.

---
 rtl/lcd_pkg.sv | 30 +++
 rtl/lcd_cmd_fifo.sv | 56 +++++
 rtl/lcd_cmd_queue.sv | 121 ++++++++++++
 tb/tb_lcd_cmd_queue.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the LCD command queue.
//   - issue FSM state encoding
//   - default byte gap / power-on gap and the SPI divider they assume
//   - LCD word field positions
package lcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } lcd_state_t;

  // SPI driver runs at divider 25; one byte takes 451 cycles, GAP leaves margin.
  localparam int LCD_SPI_DIV         = 25;
  localparam int LCD_SPI_BYTE_CYCLES = 451;
  localparam int LCD_GAP_DEFAULT     = 460;
  localparam int LCD_PWR_GAP_DEFAULT = 2;

  // 10-bit LCD word: [9] power-on, [8] D/C, [7:0] byte.
  localparam int LCD_WORD_W  = 10;
  localparam int LCD_PWR_BIT = 9;
  localparam int LCD_DC_BIT  = 8;

  // Hold-counter reload: pulse-to-pulse spacing is the gap, and SEND itself
  // plus the counter's terminal cycle account for two of those cycles.
  function automatic int hold_reload(input logic pwr, input int gap, input int pwr_gap);
    return pwr ? (pwr_gap - 2) : (gap - 2);
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// lcd_cmd_fifo: synchronous DEPTH x W FIFO with registered occupancy.
// Storage has no reset; pointers and level do. A push on a pop edge is
// accepted even when full, since the pop frees the slot on the same edge.
module lcd_cmd_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 10
) (
  input  logic                     clk_62p5mhz,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             wr_data,
  input  logic                     pop,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  // Storage write; contents are don't-care until pushed, so no reset.
  always_ff @(posedge clk_62p5mhz) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally (DEPTH is a power of two); level carries the extra bit.
  always_ff @(posedge clk_62p5mhz or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/lcd_cmd_queue.sv
// lcd_cmd_queue: buffers CPU LCD stores and paces them to the SPI driver,
// one single-cycle start pulse per word, spaced by GAP (or PWR_GAP after a
// power-on word).
// Optional feature: define LCD_QUEUE_OVF_EN to get a sticky overflow flag;
// otherwise ovf is tied low and ovf_clr is ignored.
module lcd_cmd_queue
  import lcd_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int GAP     = LCD_GAP_DEFAULT,
  parameter int PWR_GAP = LCD_PWR_GAP_DEFAULT
) (
  input  logic                   clk_62p5mhz,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [9:0]             wr_data,
  output logic                   spi_start,
  output logic [9:0]             spi_din,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   ovf,
  input  logic                   ovf_clr
);

  localparam int CNT_W = (GAP > PWR_GAP) ? $clog2(GAP) : $clog2(PWR_GAP);

  lcd_state_t       state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             pop;
  logic             fifo_empty;
  logic             fifo_full;
  logic [9:0]       fifo_head;

  lcd_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (LCD_WORD_W)
  ) u_fifo (
    .clk_62p5mhz (clk_62p5mhz),
    .reset       (reset),
    .push        (wr_en),
    .wr_data     (wr_data),
    .pop         (pop),
    .rd_data     (fifo_head),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .level       (level)
  );

  assign full      = fifo_full;
  assign empty     = fifo_empty && (state_q == IDLE);
  assign spi_start = (state_q == SEND);

  // Issue FSM: state, hold counter and the presented word.
  always_ff @(posedge clk_62p5mhz or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      spi_din    <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      if (pop) spi_din <= fifo_head;
    end
  end

  // Next-state logic. When the hold expires with a word waiting, the pop
  // happens on that same edge (IDLE is passed through without spending a
  // cycle) so back-to-back spacing is exactly the gap.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        hold_cnt_d = CNT_W'(hold_reload(spi_din[LCD_PWR_BIT], GAP, PWR_GAP));
        state_d    = HOLD;
      end
      HOLD: begin
        if (hold_cnt_q == '0) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = SEND;
          end else begin
            state_d = IDLE;
          end
        end else begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef LCD_QUEUE_OVF_EN
  logic drop;
  logic ovf_q;

  // A push the FIFO refuses (full, no pop on that edge) is the overflow event.
  assign drop = wr_en && fifo_full && !pop;
  assign ovf  = ovf_q;

  // Sticky overflow flag; a new overflow wins over a simultaneous clear.
  always_ff @(posedge clk_62p5mhz or posedge reset) begin
    if (reset)        ovf_q <= 1'b0;
    else if (drop)    ovf_q <= 1'b1;
    else if (ovf_clr) ovf_q <= 1'b0;
  end
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf            = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_cmd_queue.sv
// tb_lcd_cmd_queue: directed scenarios plus a randomized run, checked against
// a queue-and-earliest-issue-time reference model.
module tb_lcd_cmd_queue;

  localparam int DEPTH   = 16;
  localparam int GAP     = 460;
  localparam int PWR_GAP = 2;
`ifdef LCD_QUEUE_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic       clk_62p5mhz = 1'b0;
  logic       reset   = 1'b1;
  logic       wr_en   = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [9:0] wr_data = '0;
  logic       spi_start, full, empty, ovf;
  logic [9:0] spi_din;
  logic [4:0] level;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model state
  logic [9:0] mq[$];
  int         next_ok = 0;
  logic [9:0] m_din   = '0;
  logic       m_start = 1'b0;
  logic       m_ovf   = 1'b0;
  logic       m_acc   = 1'b0;
  int         obs_t[$];
  logic [9:0] obs_d[$];

  always #8 clk_62p5mhz = ~clk_62p5mhz;

  lcd_cmd_queue #(.DEPTH(DEPTH), .GAP(GAP), .PWR_GAP(PWR_GAP)) dut (
    .clk_62p5mhz (clk_62p5mhz),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .spi_start   (spi_start),
    .spi_din     (spi_din),
    .full        (full),
    .empty       (empty),
    .level       (level),
    .ovf         (ovf),
    .ovf_clr     (ovf_clr)
  );

  function automatic void model_clear();
    mq.delete();
    next_ok = 0;
    m_din   = '0;
    m_start = 1'b0;
    m_ovf   = 1'b0;
    m_acc   = 1'b0;
  endfunction

  // One clock edge of the model: the head word issues once it has been queued
  // for an edge and the previous word's gap has elapsed; a push is kept when
  // there is room or a word leaves on the same edge.
  function automatic void model_edge(input logic we, input logic [9:0] d, input logic clr);
    int   sz;
    logic pop, drop;
    if (reset) begin
      model_clear();
      return;
    end
    sz      = mq.size();
    pop     = (sz > 0) && (cyc >= next_ok);
    m_start = pop;
    m_acc   = 1'b0;
    if (pop) begin
      m_din   = mq.pop_front();
      next_ok = cyc + (m_din[9] ? PWR_GAP : GAP);
    end
    drop = we && (sz == DEPTH) && !pop;
    if (we && !drop) begin
      mq.push_back(d);
      m_acc = 1'b1;
    end
    if (drop)     m_ovf = OVF_ON;
    else if (clr) m_ovf = 1'b0;
  endfunction

  task automatic tick(input logic we, input logic [9:0] d, input logic clr);
    wr_en   = we;
    wr_data = d;
    ovf_clr = clr;
    @(posedge clk_62p5mhz);
    cyc++;
    model_edge(we, d, clr);
    @(negedge clk_62p5mhz);
    if (spi_start === 1'b1) begin
      obs_t.push_back(cyc);
      obs_d.push_back(spi_din);
    end
  endtask

  task automatic clear_obs();
    obs_t.delete();
    obs_d.delete();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    model_clear();
    repeat (3) tick(1'b0, 10'h0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if ({spi_start, spi_din} !== 11'h0) begin
      bad++; $display("FAIL reset_spi got=%0h exp=0", {spi_start, spi_din});
    end
    total++;
    if ({full, empty, level, ovf} !== {1'b0, 1'b1, 5'd0, 1'b0}) begin
      bad++; $display("FAIL reset_flags got=%0h exp=%0h", {full, empty, level, ovf}, {1'b0, 1'b1, 5'd0, 1'b0});
    end
  endtask

  task automatic test_single();
    int p;
    int eb = -1;
    apply_reset();
    clear_obs();
    tick(1'b1, 10'h0AF, 1'b0);
    p = cyc;
    total++;
    if (level !== 5'd1 || empty !== 1'b0) begin
      bad++; $display("FAIL single_level got=%0d/%0b exp=1/0", level, empty);
    end
    repeat (470) begin
      tick(1'b0, 10'h0, 1'b0);
      if (eb < 0 && empty === 1'b1) eb = cyc;
    end
    total++;
    if (obs_t.size() !== 1) begin
      bad++; $display("FAIL single_pulses got=%0d exp=1", obs_t.size());
    end
    if (obs_t.size() >= 1) begin
      total++;
      if (obs_t[0] !== p + 1 || obs_d[0] !== 10'h0AF) begin
        bad++; $display("FAIL single_issue got=%0d/%0h exp=%0d/0af", obs_t[0] - p, obs_d[0], 1);
      end
    end
    total++;
    if (eb !== p + 1 + GAP) begin
      bad++; $display("FAIL single_empty_back got=%0d exp=%0d", eb - p - 1, GAP);
    end
    total++;
    if (spi_din !== 10'h0AF) begin
      bad++; $display("FAIL single_din_held got=%0h exp=0af", spi_din);
    end
  endtask

  task automatic test_burst();
    logic [9:0] w [3];
    w[0] = 10'h1A0; w[1] = 10'h1A1; w[2] = 10'h1A2;
    apply_reset();
    clear_obs();
    for (int i = 0; i < 3 + 3 * GAP + 10; i++) begin
      if (i < 3) tick(1'b1, w[i], 1'b0);
      else       tick(1'b0, 10'h0, 1'b0);
      total++;
      if (level !== 5'(mq.size())) begin
        bad++; $display("FAIL burst_level cyc=%0d got=%0d exp=%0d", cyc, level, mq.size());
      end
    end
    total++;
    if (obs_t.size() !== 3) begin
      bad++; $display("FAIL burst_pulses got=%0d exp=3", obs_t.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs_d[i] !== w[i]) begin
          bad++; $display("FAIL burst_order idx=%0d got=%0h exp=%0h", i, obs_d[i], w[i]);
        end
      end
      for (int i = 1; i < 3; i++) begin
        total++;
        if (obs_t[i] - obs_t[i-1] !== GAP) begin
          bad++; $display("FAIL burst_spacing idx=%0d got=%0d exp=%0d", i, obs_t[i] - obs_t[i-1], GAP);
        end
      end
    end
  endtask

  task automatic test_power();
    apply_reset();
    clear_obs();
    tick(1'b1, 10'h200, 1'b0);
    tick(1'b1, 10'h0AE, 1'b0);
    repeat (480) tick(1'b0, 10'h0, 1'b0);
    total++;
    if (obs_t.size() !== 2) begin
      bad++; $display("FAIL power_pulses got=%0d exp=2", obs_t.size());
    end else begin
      total++;
      if (obs_t[1] - obs_t[0] !== PWR_GAP || obs_d[0] !== 10'h200 || obs_d[1] !== 10'h0AE) begin
        bad++; $display("FAIL power_spacing got=%0d %0h %0h exp=%0d 200 0ae", obs_t[1] - obs_t[0], obs_d[0], obs_d[1], PWR_GAP);
      end
    end
    total++;
    if (empty !== 1'b1) begin
      bad++; $display("FAIL power_drained got=%0b exp=1", empty);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    clear_obs();
    tick(1'b1, 10'h0AA, 1'b0);
    repeat (3) tick(1'b0, 10'h0, 1'b0);
    for (int i = 0; i < 17; i++) tick(1'b1, 10'(i), 1'b0);
    total++;
    if (full !== 1'b1 || level !== 5'd16) begin
      bad++; $display("FAIL ovf_full got=%0b/%0d exp=1/16", full, level);
    end
    total++;
    if (ovf !== OVF_ON) begin
      bad++; $display("FAIL ovf_flag got=%0b exp=%0b", ovf, OVF_ON);
    end
    tick(1'b0, 10'h0, 1'b1);
    total++;
    if (ovf !== 1'b0 || full !== 1'b1) begin
      bad++; $display("FAIL ovf_clear got=%0b/%0b exp=0/1", ovf, full);
    end
    repeat (17 * GAP + 10) tick(1'b0, 10'h0, 1'b0);
    total++;
    if (obs_t.size() !== 17) begin
      bad++; $display("FAIL ovf_drain_count got=%0d exp=17", obs_t.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        total++;
        if (obs_d[i+1] !== 10'(i)) begin
          bad++; $display("FAIL ovf_drain idx=%0d got=%0h exp=%0h", i, obs_d[i+1], i);
        end
      end
    end
    total++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      bad++; $display("FAIL ovf_end got=%0b/%0b exp=1/0", empty, full);
    end
  endtask

  task automatic test_push_on_pop_full();
    int   n   = 0;
    logic got = 1'b0;
    apply_reset();
    clear_obs();
    tick(1'b1, 10'h0BB, 1'b0);
    repeat (3) tick(1'b0, 10'h0, 1'b0);
    for (int i = 0; i < 16; i++) tick(1'b1, 10'h100 + 10'(i), 1'b0);
    while (!got && n < GAP + 20) begin
      tick(1'b1, 10'h1C5, 1'b0);
      n++;
      got = m_acc;
      total++;
      if (level !== 5'd16 || full !== 1'b1) begin
        bad++; $display("FAIL pop_full_level cyc=%0d got=%0d exp=16", cyc, level);
      end
    end
    total++;
    if (!got) begin
      bad++; $display("FAIL pop_full_timeout got=%0d cycles exp=accept", n);
    end
    total++;
    if (spi_start !== 1'b1 || spi_din !== 10'h100) begin
      bad++; $display("FAIL pop_full_issue got=%0b/%0h exp=1/100", spi_start, spi_din);
    end
    tick(1'b0, 10'h0, 1'b1);
    repeat (17 * GAP + 10) tick(1'b0, 10'h0, 1'b0);
    total++;
    if (obs_t.size() !== 18) begin
      bad++; $display("FAIL pop_full_count got=%0d exp=18", obs_t.size());
    end else begin
      total++;
      if (obs_d[0] !== 10'h0BB || obs_d[17] !== 10'h1C5) begin
        bad++; $display("FAIL pop_full_ends got=%0h/%0h exp=0bb/1c5", obs_d[0], obs_d[17]);
      end
      for (int i = 0; i < 16; i++) begin
        total++;
        if (obs_d[i+1] !== 10'h100 + 10'(i)) begin
          bad++; $display("FAIL pop_full_order idx=%0d got=%0h exp=%0h", i, obs_d[i+1], 10'h100 + 10'(i));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int p;
    apply_reset();
    clear_obs();
    for (int i = 0; i < 6; i++) tick(1'b1, 10'h011 + 10'(i), 1'b0);
    repeat (10) tick(1'b0, 10'h0, 1'b0);
    total++;
    if (level !== 5'd5 || spi_din !== 10'h011) begin
      bad++; $display("FAIL mid_pre got=%0d/%0h exp=5/011", level, spi_din);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({spi_start, spi_din, full, empty, level, ovf} !== {1'b0, 10'h0, 1'b0, 1'b1, 5'd0, 1'b0}) begin
      bad++; $display("FAIL mid_async got=%0h exp=%0h", {spi_start, spi_din, full, empty, level, ovf},
                      {1'b0, 10'h0, 1'b0, 1'b1, 5'd0, 1'b0});
    end
    model_clear();
    repeat (3) tick(1'b0, 10'h0, 1'b0);
    reset = 1'b0;
    clear_obs();
    repeat (1000) tick(1'b0, 10'h0, 1'b0);
    total++;
    if (obs_t.size() !== 0 || empty !== 1'b1) begin
      bad++; $display("FAIL mid_quiet got=%0d/%0b exp=0/1", obs_t.size(), empty);
    end
    tick(1'b1, 10'h055, 1'b0);
    p = cyc;
    repeat (3) tick(1'b0, 10'h0, 1'b0);
    total++;
    if (obs_t.size() !== 1) begin
      bad++; $display("FAIL mid_new_count got=%0d exp=1", obs_t.size());
    end else begin
      total++;
      if (obs_t[0] !== p + 1 || obs_d[0] !== 10'h055) begin
        bad++; $display("FAIL mid_new got=%0d/%0h exp=1/055", obs_t[0] - p, obs_d[0]);
      end
    end
    repeat (GAP) tick(1'b0, 10'h0, 1'b0);
  endtask

  task automatic test_random();
    logic       we, clr;
    logic [9:0] d;
    logic [19:0] got_v, exp_v;
    apply_reset();
    clear_obs();
    for (int i = 0; i < 6000; i++) begin
      we    = ($urandom_range(0, 999) < ((i < 3000) ? 200 : 3));
      d     = 10'($urandom);
      d[9]  = ($urandom_range(0, 3) == 0);
      clr   = ($urandom_range(0, 49) == 0);
      tick(we, d, clr);
      got_v = {spi_start, spi_din, full, empty, level, ovf};
      exp_v = {m_start, m_din, (mq.size() == DEPTH), (mq.size() == 0 && cyc >= next_ok),
               5'(mq.size()), m_ovf};
      total++;
      if (got_v !== exp_v) begin
        bad++; $display("FAIL random cyc=%0d got=%05h exp=%05h", cyc, got_v, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_power();
    test_overflow();
    test_push_on_pop_full();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
